i2c_target_responder: RTL and testbench

I2C target (slave) engine: the responding end of the bus for our I2C master controller, used as the loopback peer in the APB I2C subsystem bench and as an on-chip target. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs, and delivers write bytes. It also sources read bytes through a simple local handshake. Standard I2C R/W polarity: bit 0 = 1 means master read.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_bus_sync.sv | 56 +++++
 rtl/i2c_target_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_pkg : shared constants and FSM state type for the I2C target engine
// Rev 1.0
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h6B;
  localparam logic       I2C_RW_READ      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_ACK = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_ACK  = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_bus_sync : SCL/SDA synchronizers, registered edge and START/STOP pulses
// Rev 1.0
// ---------------------------------------------------------------------------
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic r_scl_meta, r_scl_s, r_scl_prev;
  logic r_sda_meta, r_sda_s, r_sda_prev;
  logic r_scl_rise, r_scl_fall, r_start, r_stop;

  // Idle bus is high, so resetting the pipeline high avoids false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_meta <= 1'b1;
      r_scl_s    <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_s    <= 1'b1;
      r_sda_prev <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_meta <= scl_in;
      r_scl_s    <= r_scl_meta;
      r_scl_prev <= r_scl_s;
      r_sda_meta <= sda_in;
      r_sda_s    <= r_sda_meta;
      r_sda_prev <= r_sda_s;
      r_scl_rise <= r_scl_s & ~r_scl_prev;
      r_scl_fall <= ~r_scl_s & r_scl_prev;
      r_start    <= r_scl_s & r_scl_prev & r_sda_prev & ~r_sda_s;
      r_stop     <= r_scl_s & r_scl_prev & ~r_sda_prev & r_sda_s;
    end
  end

  assign scl_rise  = r_scl_rise;
  assign scl_fall  = r_scl_fall;
  assign sda_s     = r_sda_prev;
  assign start_det = r_start;
  assign stop_det  = r_stop;

endmodule
`default_nettype wire

// File: rtl/i2c_target_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_target_responder : 7-bit address I2C target with local rx/tx handshake
// Rev 1.0
// ---------------------------------------------------------------------------
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  logic w_scl_rise, w_scl_fall, w_sda_s, w_start, w_stop;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .sda_s     (w_sda_s),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  i2c_state_e r_state, w_state_n;
  logic [2:0] r_cnt, w_cnt_n;
  logic [6:0] r_shift, w_shift_n;
  logic [7:0] r_rx_data, w_rx_data_n;
  logic       r_sda_oe, w_sda_oe_n;
  logic       r_rx_valid, w_rx_valid_n;
  logic       r_tx_req, w_tx_req_n;
  logic       r_busy, w_busy_n;
  logic       r_rw, w_rw_n;
  logic       r_phase, w_phase_n;
  logic       r_ack, w_ack_n;
  logic [7:0] w_byte;

  assign w_byte = {r_shift, w_sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd7;
      r_shift    <= 7'h00;
      r_rx_data  <= 8'h00;
      r_sda_oe   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_busy     <= 1'b0;
      r_rw       <= 1'b0;
      r_phase    <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_shift    <= w_shift_n;
      r_rx_data  <= w_rx_data_n;
      r_sda_oe   <= w_sda_oe_n;
      r_rx_valid <= w_rx_valid_n;
      r_tx_req   <= w_tx_req_n;
      r_busy     <= w_busy_n;
      r_rw       <= w_rw_n;
      r_phase    <= w_phase_n;
      r_ack      <= w_ack_n;
    end
  end

  // r_phase marks the second half of an ACK slot, or "byte complete" in READ.
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_shift_n    = r_shift;
    w_rx_data_n  = r_rx_data;
    w_sda_oe_n   = r_sda_oe;
    w_rx_valid_n = 1'b0;
    w_tx_req_n   = 1'b0;
    w_busy_n     = r_busy;
    w_rw_n       = r_rw;
    w_phase_n    = r_phase;
    w_ack_n      = r_ack;

    if (w_stop) begin
      w_state_n  = ST_IDLE;
      w_sda_oe_n = 1'b0;
      w_busy_n   = 1'b0;
      w_phase_n  = 1'b0;
    end else if (w_start) begin
      w_state_n  = ST_ADDR;
      w_cnt_n    = 3'd7;
      w_sda_oe_n = 1'b0;
      w_busy_n   = 1'b0;
      w_phase_n  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
        end
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_n = w_byte[6:0];
            w_cnt_n   = r_cnt - 3'd1;
            if (r_cnt == 3'd0) begin
              w_phase_n = 1'b0;
              if (w_byte[7:1] == SLAVE_ADDR) begin
                w_state_n = ST_ADDR_ACK;
                w_busy_n  = 1'b1;
                w_rw_n    = w_byte[0];
              end else begin
                w_state_n = ST_WAIT_STOP;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_oe_n = 1'b1;
              w_phase_n  = 1'b1;
            end else begin
              w_phase_n = 1'b0;
              if (r_rw == I2C_RW_READ) begin
                w_state_n  = ST_READ;
                w_shift_n  = tx_data[6:0];
                w_sda_oe_n = ~tx_data[7];
              end else begin
                w_state_n  = ST_WRITE;
                w_sda_oe_n = 1'b0;
              end
            end
          end else if (w_scl_rise && r_phase && (r_rw == I2C_RW_READ)) begin
            w_tx_req_n = 1'b1;
          end
        end
        ST_WRITE: begin
          if (w_scl_rise) begin
            w_shift_n = w_byte[6:0];
            w_cnt_n   = r_cnt - 3'd1;
            if (r_cnt == 3'd0) begin
              w_rx_data_n  = w_byte;
              w_rx_valid_n = rx_ready;
              w_ack_n      = rx_ready;
              w_phase_n    = 1'b0;
              w_state_n    = ST_WRITE_ACK;
            end
          end
        end
        ST_WRITE_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_oe_n = r_ack;
              w_phase_n  = 1'b1;
            end else begin
              w_sda_oe_n = 1'b0;
              w_phase_n  = 1'b0;
              w_busy_n   = r_ack;
              w_state_n  = r_ack ? ST_WRITE : ST_WAIT_STOP;
            end
          end
        end
        ST_READ: begin
          if (w_scl_rise) begin
            w_cnt_n = r_cnt - 3'd1;
            if (r_cnt == 3'd0) w_phase_n = 1'b1;
          end else if (w_scl_fall) begin
            if (r_phase) begin
              w_sda_oe_n = 1'b0;
              w_phase_n  = 1'b0;
              w_state_n  = ST_READ_ACK;
            end else begin
              w_sda_oe_n = ~r_shift[6];
              w_shift_n  = {r_shift[5:0], 1'b0};
            end
          end
        end
        ST_READ_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda_s) begin
              w_tx_req_n = 1'b1;
              w_phase_n  = 1'b1;
            end else begin
              w_state_n = ST_WAIT_STOP;
              w_busy_n  = 1'b0;
            end
          end else if (w_scl_fall && r_phase) begin
            w_phase_n  = 1'b0;
            w_state_n  = ST_READ;
            w_shift_n  = tx_data[6:0];
            w_sda_oe_n = ~tx_data[7];
          end
        end
        ST_WAIT_STOP: begin
          w_sda_oe_n = 1'b0;
          w_busy_n   = 1'b0;
        end
        default: begin
          w_state_n  = ST_IDLE;
          w_sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe    = r_sda_oe;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_req    = r_tx_req;
  assign busy      = r_busy;
  assign start_det = w_start;
  assign stop_det  = w_stop;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_i2c_target_responder : bit-banged I2C master with a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_i2c_target_responder;

  localparam int Q = 5;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe, rx_valid, tx_req, busy, start_det, stop_det;
  logic [7:0] rx_data;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .busy      (busy),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model of what the target must do
  logic       m_live = 1'b0;
  logic       m_rw = 1'b0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] tx_list[$];
  int         m_rd_idx = 0;
  int         resp_idx = 0;
  int         exp_ntx = 0;
  logic       exp_pull = 1'b0;
  logic       chk_en = 1'b0;

  int   n_rxv = 0, n_txreq = 0, n_start = 0, n_stop = 0;
  logic prev_rxv = 1'b0, prev_txr = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (chk_en) check("sda_oe_bit", sda_oe, exp_pull);
        if (rx_valid) begin
          n_rxv++;
          check("rx_valid_width", prev_rxv, 1'b0);
          check("rx_valid_expected", exp_rx_q.size() != 0, 1'b1);
          if (exp_rx_q.size() != 0) check("rx_data", rx_data, exp_rx_q.pop_front());
        end
        if (tx_req) begin
          n_txreq++;
          check("tx_req_width", prev_txr, 1'b0);
        end
        if (start_det) n_start++;
        if (stop_det) n_stop++;
      end
      prev_rxv = rx_valid;
      prev_txr = tx_req;
    end
  end

  // Local read-data source: answers each tx_req with the next listed byte
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx_req) begin
        if (resp_idx < tx_list.size()) tx_data = tx_list[resp_idx];
        resp_idx++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_cycle(input logic b, input logic exp, output logic line);
    sda_m = b;
    wclk(Q);
    exp_pull = exp;
    scl_m = 1'b1;
    chk_en = 1'b1;
    wclk(Q);
    line = sda_line;
    wclk(Q);
    chk_en = 1'b0;
    scl_m = 1'b0;
    wclk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    sda_m = 1'b0;
    wclk(Q);
    scl_m = 1'b0;
    wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    sda_m = 1'b1;
    wclk(2 * Q);
    m_live = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic is_addr, output logic acked);
    logic ea, line;
    if (is_addr) begin
      m_rw   = b[0];
      m_live = (b[7:1] == 7'h6B);
      ea     = m_live;
      if (m_live && m_rw) exp_ntx++;
    end else begin
      ea = m_live && !m_rw && rx_ready;
      if (ea) exp_rx_q.push_back(b);
      if (m_live && !m_rw) m_live = rx_ready;
    end
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], 1'b0, line);
    bit_cycle(1'b1, ea, line);
    acked = ~line;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] got);
    logic [7:0] eb;
    logic line, live;
    live = m_live && m_rw;
    eb = 8'h00;
    if (live) begin
      eb = tx_list[m_rd_idx];
      m_rd_idx++;
    end
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, live && !eb[i], line);
      got[i] = line;
    end
    bit_cycle(~mack, 1'b0, line);
    if (live && mack) exp_ntx++;
    if (!mack) m_live = 1'b0;
  endtask

  initial begin
    logic       ack, line;
    logic [7:0] got;
    logic [7:0] addr_w;
    int         s0, p0, r0, t0;

    wclk(3);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_start_det", start_det, 1'b0);
    check("rst_stop_det", stop_det, 1'b0);
    rst_n = 1'b1;
    wclk(4);

    // Write 0xAA to 0x6B
    s0 = n_start; p0 = n_stop; r0 = n_rxv;
    i2c_start();
    wr_byte(8'hD6, 1'b1, ack);
    check("t1_addr_ack", ack, 1'b1);
    check("t1_busy", busy, 1'b1);
    wr_byte(8'hAA, 1'b0, ack);
    check("t1_data_ack", ack, 1'b1);
    i2c_stop();
    check("t1_rx_data", rx_data, 8'hAA);
    check("t1_rx_valid_count", n_rxv - r0, 1);
    check("t1_start_count", n_start - s0, 1);
    check("t1_stop_count", n_stop - p0, 1);
    check("t1_busy_end", busy, 1'b0);

    // Wrong address 0x6A
    r0 = n_rxv; p0 = n_stop;
    i2c_start();
    wr_byte(8'hD4, 1'b1, ack);
    check("t2_addr_nack", ack, 1'b0);
    check("t2_busy", busy, 1'b0);
    wr_byte(8'h55, 1'b0, ack);
    check("t2_data_ignored", ack, 1'b0);
    i2c_stop();
    check("t2_no_rx_valid", n_rxv - r0, 0);
    check("t2_stop_count", n_stop - p0, 1);

    // Read two bytes: master ACK then NACK
    tx_list = '{8'h5C, 8'h3F};
    m_rd_idx = 0; resp_idx = 0; t0 = n_txreq;
    i2c_start();
    wr_byte(8'hD7, 1'b1, ack);
    check("t3_addr_ack", ack, 1'b1);
    rd_byte(1'b1, got);
    check("t3_byte0", got, 8'h5C);
    rd_byte(1'b0, got);
    check("t3_byte1", got, 8'h3F);
    check("t3_released", sda_oe, 1'b0);
    i2c_stop();
    check("t3_tx_req_count", n_txreq - t0, 2);

    // rx_ready low: data byte NACKed, following byte ignored
    rx_ready = 1'b0; r0 = n_rxv;
    i2c_start();
    wr_byte(8'hD6, 1'b1, ack);
    check("t4_addr_ack", ack, 1'b1);
    wr_byte(8'h12, 1'b0, ack);
    check("t4_data_nack", ack, 1'b0);
    check("t4_busy_drop", busy, 1'b0);
    wr_byte(8'h34, 1'b0, ack);
    check("t4_ignored", ack, 1'b0);
    i2c_stop();
    rx_ready = 1'b1;
    check("t4_no_rx_valid", n_rxv - r0, 0);

    // Repeated START after a write address, then a one-byte read
    tx_list = '{8'hA5};
    m_rd_idx = 0; resp_idx = 0; s0 = n_start;
    i2c_start();
    wr_byte(8'hD6, 1'b1, ack);
    check("t5_waddr_ack", ack, 1'b1);
    i2c_start();
    wr_byte(8'hD7, 1'b1, ack);
    check("t5_raddr_ack", ack, 1'b1);
    rd_byte(1'b0, got);
    check("t5_byte", got, 8'hA5);
    i2c_stop();
    check("t5_start_count", n_start - s0, 2);

    // Reset while the target is pulling SDA in the address ACK slot
    addr_w = 8'hD6;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_cycle(addr_w[i], 1'b0, line);
    sda_m = 1'b1;
    wclk(Q);
    scl_m = 1'b1;
    wclk(2);
    check("t6_ack_driven", sda_oe, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_release", sda_oe, 1'b0);
    check("t6_rx_data", rx_data, 8'h00);
    check("t6_busy", busy, 1'b0);
    check("t6_rx_valid", rx_valid, 1'b0);
    check("t6_tx_req", tx_req, 1'b0);
    wclk(2);
    rst_n = 1'b1;
    m_live = 1'b0;
    wclk(Q);
    scl_m = 1'b0;
    wclk(Q);
    i2c_stop();
    check("t6_idle_after", busy, 1'b0);

    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("tx_req_total", n_txreq, exp_ntx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
